// File: rtl/mdu_pkg.sv
// Opcode, state and latency definitions shared by the E-stage multiply/divide unit.
// Defining MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
package mdu_pkg;

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MFHI  = 4'd5,
      OP_MFLO  = 4'd6,
      OP_MTHI  = 4'd7,
      OP_MTLO  = 4'd8,
      OP_MADD  = 4'd9,
      OP_MADDU = 4'd10,
      OP_MSUB  = 4'd11,
      OP_MSUBU = 4'd12
   } mdu_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_e;

   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;

`ifdef MDU_MADD_EN
   localparam bit MADD_EN = 1'b1;
`else
   localparam bit MADD_EN = 1'b0;
`endif

   function automatic logic is_div_op(input logic [3:0] op);
      return op inside {OP_DIV, OP_DIVU};
   endfunction

   // Ops that occupy the unit for several cycles and commit through the shadow registers.
   function automatic logic is_long_op(input logic [3:0] op);
      return (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) ||
             (MADD_EN && (op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU}));
   endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit {hi,lo} result of a multiply/divide/accumulate op.
// Accumulate results are only consumed when MDU_MADD_EN is defined.
module mdu_calc
   import mdu_pkg::*;
(
   input  logic [3:0]  i_op,
   input  logic [31:0] i_rs,
   input  logic [31:0] i_rt,
   input  logic [31:0] i_hi,
   input  logic [31:0] i_lo,
   output logic [63:0] o_result
);

   logic [63:0]        w_hilo;
   logic [63:0]        w_prod_s;
   logic [63:0]        w_prod_u;
   logic signed [32:0] w_dvd_s;
   logic signed [32:0] w_dvs_s;
   logic [31:0]        w_quo_s;
   logic [31:0]        w_rem_s;
   logic               w_div_zero;

   assign w_hilo     = {i_hi, i_lo};
   assign w_prod_s   = $signed({{32{i_rs[31]}}, i_rs}) * $signed({{32{i_rt[31]}}, i_rt});
   assign w_prod_u   = {32'h0, i_rs} * {32'h0, i_rt};
   assign w_div_zero = (i_rt == 32'h0);

   // 33-bit signed divide so 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
   assign w_dvd_s = {i_rs[31], i_rs};
   assign w_dvs_s = {i_rt[31], i_rt};
   assign w_quo_s = 32'(w_dvd_s / w_dvs_s);
   assign w_rem_s = 32'(w_dvd_s % w_dvs_s);

   always_comb begin
      o_result = w_hilo;
      case (i_op)
         OP_MULT:  o_result = w_prod_s;
         OP_MULTU: o_result = w_prod_u;
         OP_DIV:   if (!w_div_zero) o_result = {w_rem_s, w_quo_s};
         OP_DIVU:  if (!w_div_zero) o_result = {i_rs % i_rt, i_rs / i_rt};
         OP_MADD:  o_result = w_hilo + w_prod_s;
         OP_MADDU: o_result = w_hilo + w_prod_u;
         OP_MSUB:  o_result = w_hilo - w_prod_s;
         OP_MSUBU: o_result = w_hilo - w_prod_u;
         default:  o_result = w_hilo;
      endcase
   end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: architectural HI/LO, fixed-latency busy window, MFHI/MFLO read port.
// Defining MDU_MADD_EN adds the multiply-accumulate ops (see mdu_pkg).
module e_mdu
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  mdu_op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic        busy,
   output logic [31:0] md_out,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   mdu_state_e  r_state;
   mdu_state_e  w_state_next;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_next;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic [31:0] r_shadow_hi;
   logic [31:0] r_shadow_lo;
   logic [63:0] w_result;
   logic        w_load_shadow;
   logic        w_commit;
   logic        w_hi_we;
   logic        w_lo_we;

   mdu_calc u_calc (
      .i_op     (mdu_op),
      .i_rs     (rs_data),
      .i_rt     (rt_data),
      .i_hi     (r_hi),
      .i_lo     (r_lo),
      .o_result (w_result)
   );

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      w_state_next  = r_state;
      w_cnt_next    = r_cnt;
      w_load_shadow = 1'b0;
      w_commit      = 1'b0;
      w_hi_we       = 1'b0;
      w_lo_we       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (is_long_op(mdu_op)) begin
                  w_load_shadow = 1'b1;
                  w_cnt_next    = is_div_op(mdu_op) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                  w_state_next  = ST_RUN;
               end
               w_hi_we = (mdu_op == OP_MTHI);
               w_lo_we = (mdu_op == OP_MTLO);
            end
         end
         ST_RUN: begin
            // Any start seen here is dropped; the hazard unit never issues one.
            w_cnt_next = r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
               w_commit     = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 4'd0;
         r_hi        <= 32'h0;
         r_lo        <= 32'h0;
         r_shadow_hi <= 32'h0;
         r_shadow_lo <= 32'h0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         if (w_load_shadow) {r_shadow_hi, r_shadow_lo} <= w_result;
         if (w_commit) begin
            r_hi <= r_shadow_hi;
            r_lo <= r_shadow_lo;
         end else begin
            if (w_hi_we) r_hi <= rs_data;
            if (w_lo_we) r_lo <= rs_data;
         end
      end
   end

   always_comb begin
      md_out = 32'h0;
      if (mdu_op == OP_MFHI) md_out = r_hi;
      else if (mdu_op == OP_MFLO) md_out = r_lo;
   end

   assign busy   = (r_state == ST_RUN);
   assign hi_out = r_hi;
   assign lo_out = r_lo;

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: directed corner cases plus random ops against a behavioural model.
// Build with MDU_MADD_EN defined to expect the accumulate ops to take effect.
module tb_e_mdu;
   import mdu_pkg::*;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;
`ifdef MDU_MADD_EN
   localparam bit TB_MADD = 1'b1;
`else
   localparam bit TB_MADD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  mdu_op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        busy;
   logic [31:0] md_out;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .mdu_op  (mdu_op),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .busy    (busy),
      .md_out  (md_out),
      .hi_out  (hi_out),
      .lo_out  (lo_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] md_q[$];
   exp_t        mon_e;
   logic [31:0] mon_md;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] m_hi = 32'h0;
   logic [31:0] m_lo = 32'h0;
   bit          prev_busy = 1'b0;
   int          busy_len = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference behaviour straight from the ISA definition of each op.
   function automatic logic [63:0] ref_model(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] hilo);
      longint      sa, sb;
      logic [63:0] ua, ub, ps, pu;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'h0, a};
      ub = {32'h0, b};
      ps = 64'(sa * sb);
      pu = ua * ub;
      case (op)
         OP_MULT:  return ps;
         OP_MULTU: return pu;
         OP_DIV: begin
            if (b == 32'h0) return hilo;
            return {32'(sa % sb), 32'(sa / sb)};
         end
         OP_DIVU: begin
            if (b == 32'h0) return hilo;
            return {32'(ua % ub), 32'(ua / ub)};
         end
         OP_MADD:  return hilo + ps;
         OP_MADDU: return hilo + pu;
         OP_MSUB:  return hilo - ps;
         OP_MSUBU: return hilo - pu;
         default:  return hilo;
      endcase
   endfunction

   function automatic bit tb_long(input logic [3:0] op);
      if (op >= 4'd1 && op <= 4'd4) return 1'b1;
      if (op >= 4'd9 && op <= 4'd12) return TB_MADD;
      return 1'b0;
   endfunction

   // Monitor: commits are checked when busy falls, reads whenever MFHI/MFLO is presented.
   always @(negedge clk) begin
      if (!reset) begin
         exp_q.delete();
         prev_busy = 1'b0;
         busy_len  = 0;
      end else begin
         if (busy) begin
            busy_len++;
         end else if (prev_busy) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL commit_unexpected: busy fell with no op outstanding (t=%0t)", $time);
            end else begin
               mon_e = exp_q.pop_front();
               check("commit_hi", hi_out, mon_e.hi);
               check("commit_lo", lo_out, mon_e.lo);
               check("busy_len", 32'(busy_len), 32'(mon_e.cycles));
            end
            busy_len = 0;
         end
         prev_busy = busy;
         if (start && !busy && (mdu_op == OP_MFHI || mdu_op == OP_MFLO)) begin
            if (md_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL md_unexpected: read with no expectation queued (t=%0t)", $time);
            end else begin
               mon_md = md_q.pop_front();
               check(mdu_op == OP_MFHI ? "mfhi" : "mflo", md_out, mon_md);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 40) begin
         tick();
         n++;
      end
      if (busy) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_idle: busy=%0b after %0d cycles, expected 0", busy, n);
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] r;
      wait_idle();
      start   = 1'b1;
      mdu_op  = op;
      rs_data = a;
      rt_data = b;
      if (tb_long(op)) begin
         r = ref_model(op, a, b, {m_hi, m_lo});
         exp_q.push_back('{r[63:32], r[31:0], (op == OP_DIV || op == OP_DIVU) ? DIV_N : MULT_N});
         m_hi = r[63:32];
         m_lo = r[31:0];
      end else if (op == OP_MTHI) begin
         m_hi = a;
      end else if (op == OP_MTLO) begin
         m_lo = a;
      end else if (op == OP_MFHI) begin
         md_q.push_back(m_hi);
      end else if (op == OP_MFLO) begin
         md_q.push_back(m_lo);
      end
      tick();
      start  = 1'b0;
      mdu_op = OP_NONE;
   endtask

   task automatic readback();
      issue(OP_MFHI, 32'h0, 32'h0);
      issue(OP_MFLO, 32'h0, 32'h0);
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] op;
      reset   = 1'b0;
      start   = 1'b0;
      mdu_op  = OP_NONE;
      rs_data = 32'h0;
      rt_data = 32'h0;
      repeat (3) tick();
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_hi", hi_out, 32'h0);
      check("rst_lo", lo_out, 32'h0);
      check("rst_md", md_out, 32'h0);
      reset = 1'b1;
      tick();

      // Signed and unsigned multiply of -1 by 2.
      issue(OP_MULT, 32'hFFFF_FFFF, 32'h2);
      wait_idle();
      check("mult_hi", hi_out, 32'hFFFF_FFFF);
      check("mult_lo", lo_out, 32'hFFFF_FFFE);
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'h2);
      wait_idle();
      check("multu_hi", hi_out, 32'h0000_0001);
      check("multu_lo", lo_out, 32'hFFFF_FFFE);

      // Division sign rules and the overflow corner.
      issue(OP_DIV, 32'hFFFF_FFF9, 32'h2);
      wait_idle();
      check("div_lo", lo_out, 32'hFFFF_FFFD);
      check("div_hi", hi_out, 32'hFFFF_FFFF);
      issue(OP_DIVU, 32'h7, 32'h2);
      wait_idle();
      check("divu_lo", lo_out, 32'h3);
      check("divu_hi", hi_out, 32'h1);
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle();
      check("divovf_lo", lo_out, 32'h8000_0000);
      check("divovf_hi", hi_out, 32'h0);

      // Moves to HI/LO on consecutive cycles, then reads.
      issue(OP_MTHI, 32'h1234_5678, 32'h0);
      check("mthi_busy", 32'(busy), 32'h0);
      issue(OP_MTLO, 32'h9ABC_DEF0, 32'h0);
      check("mtlo_busy", 32'(busy), 32'h0);
      check("mt_hi", hi_out, 32'h1234_5678);
      check("mt_lo", lo_out, 32'h9ABC_DEF0);
      readback();

      // Divide by zero keeps HI/LO.
      issue(OP_MTHI, 32'hAAAA_0000, 32'h0);
      issue(OP_MTLO, 32'h0000_5555, 32'h0);
      issue(OP_DIVU, 32'h1234_0000, 32'h0);
      wait_idle();
      check("div0_hi", hi_out, 32'hAAAA_0000);
      check("div0_lo", lo_out, 32'h0000_5555);

      // Async reset in the third busy cycle aborts the multiply.
      issue(OP_MULT, 32'h0001_0000, 32'h0001_0000);
      tick();
      tick();
      #2;
      reset = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'h0);
      check("abort_hi", hi_out, 32'h0);
      check("abort_lo", lo_out, 32'h0);
      @(negedge clk);
      #1;
      reset = 1'b1;
      m_hi  = 32'h0;
      m_lo  = 32'h0;
      repeat (20) tick();
      check("abort_late_busy", 32'(busy), 32'h0);
      check("abort_late_hi", hi_out, 32'h0);
      check("abort_late_lo", lo_out, 32'h0);

      // Starts while busy are ignored; the original product still commits.
      issue(OP_MULT, 32'h3, 32'h4);
      start   = 1'b1;
      mdu_op  = OP_MTHI;
      rs_data = 32'hDEAD_BEEF;
      tick();
      mdu_op  = OP_DIV;
      rs_data = 32'd100;
      rt_data = 32'd7;
      tick();
      mdu_op  = OP_MTLO;
      tick();
      start  = 1'b0;
      mdu_op = OP_NONE;
      wait_idle();
      check("ignore_hi", hi_out, 32'h0);
      check("ignore_lo", lo_out, 32'hC);

      // Unsigned accumulate carrying out of LO.
      issue(OP_MTHI, 32'h0, 32'h0);
      issue(OP_MTLO, 32'hFFFF_FFFF, 32'h0);
      issue(OP_MADDU, 32'h1, 32'h1);
      wait_idle();
      check("maddu_hi", hi_out, TB_MADD ? 32'h1 : 32'h0);
      check("maddu_lo", lo_out, TB_MADD ? 32'h0 : 32'hFFFF_FFFF);

      // Random op mix, each followed by a HI/LO readback.
      for (int i = 0; i < 60; i++) begin
         op = 4'($urandom_range(0, 15));
         if (op == OP_MFHI || op == OP_MFLO) op = OP_MULT;
         issue(op, rnd_operand(), rnd_operand());
         readback();
      end

      wait_idle();
      repeat (3) tick();
      check("exp_q_drained", 32'(exp_q.size()), 32'h0);
      check("md_q_drained", 32'(md_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit of the pipelined MIPS core, fed by the forwarded GRF read values (rs/rt) carried through the D/E pipeline register.
- Holds the architectural HI/LO registers and models fixed multi-cycle latency for MULT/DIV.
- Exposes busy to the hazard unit.
- MFHI/MFLO results flow to M/W and are written back into the GRF.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1-15).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1-15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; clears all state.
- start  input  1  E-stage instruction is an MDU op this cycle (already qualified by stall/flush).
- mdu_op  input  4  operation code (encodings in package).
- rs_data  input  32  forwarded rs operand.
- rt_data  input  32  forwarded rt operand.
- busy  output  1  MULT/DIV in progress.
- md_out  output  32  HI for MFHI, LO for MFLO, else 0.
- hi_out  output  32  current HI.
- lo_out  output  32  current LO.

Behaviour:
- Reset (async, reset=0):
  - HI=0, LO=0, busy=0, counter=0, shadow HI/LO=0.
  - Reset mid-operation aborts the op; no commit occurs after release.
- States: IDLE, RUN. The counter is a 4-bit down-counter.
- IDLE, start with op MULT/MULTU/DIV/DIVU at edge k:
  - Compute the result from rs/rt sampled at that edge into the shadow registers.
  - Load the counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy=1 for cycles k+1 through k+N.
- RUN:
  - Counter decrements each edge.
  - On the edge where counter==1: HI/LO take the shadow values, busy drops, return to IDLE.
  - New HI/LO are visible in the first cycle with busy=0.
- MTHI/MTLO in IDLE: HI (respectively LO) gets rs_data at the next edge; busy stays 0.
- MFHI/MFLO: md_out is combinational from the current HI/LO. It is not gated by busy; the hazard unit must stall while busy.
- start asserted while busy (any op): ignored, with no state change. The hazard unit guarantees this never happens; the bench checks it is harmless.
- MULT: signed 64-bit product; HI=[63:32], LO=[31:0]. MULTU: unsigned.
- DIV: LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient and remainder.
- Division by zero (rt_data==0):
  - busy sequence runs normally.
  - HI/LO are unchanged at commit.
- Undefined mdu_op with start=1: no effect.
- hi_out and lo_out always reflect the committed registers.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - Adds MADD, MADDU, MSUB, MSUBU.
  - {HI,LO} ± the signed or unsigned 64-bit product, using MULT_CYCLES latency.
  - The accumulate source is {HI,LO} sampled at the start edge.
- Undefined: those encodings are treated as undefined ops with no effect.

Decomposition:
- Package mdu_pkg holds:
  - mdu_op encodings: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12.
  - IDLE/RUN state encoding.
  - Default cycle constants.
- Sub-module mdu_calc: purely combinational 64-bit result ({hi,lo}) from op, rs, rt, and the current HI/LO. e_mdu keeps the state machine, counter, shadow and architectural registers.

Test Plan:
1. MULT: rs=0xFFFFFFFF, rt=2, start at edge k.
   - busy=1 for exactly 5 cycles.
   - Then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
   - Repeat with MULTU: HI=0x00000001, LO=0xFFFFFFFE.
2. DIV: rs=0xFFFFFFF9 (-7), rt=2.
   - After 10 busy cycles: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   - DIVU 7/2: LO=3, HI=1.
   - DIV 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
3. MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles.
   - busy stays 0.
   - MFHI gives md_out=0x12345678; MFLO gives md_out=0x9ABCDEF0.
4. HI=0xAAAA0000, LO=0x5555; DIVU with rt=0.
   - busy pulses for 10 cycles.
   - HI/LO unchanged afterwards.
5. Start MULT, assert reset=0 asynchronously mid-busy (cycle 3), then release.
   - busy=0, HI=LO=0 immediately.
   - No later commit.
   - Also: start=1 while busy is ignored, and the original result commits on schedule.
6. (MDU_MADD_EN) HI=0, LO=0xFFFFFFFF; MADDU rs=1, rt=1.
   - Result HI=1, LO=0.
   - Without the macro, the same op leaves HI/LO unchanged.
